ioctl_upload_reader: RTL and testbench

IOCTL_UPLOAD_READER -- requirements
Module: ioctl_upload_reader

---
 rtl/ioctl_upload_reader.sv | 118 +++++++++++
 tb/tb_ioctl_upload_reader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_upload_reader.sv
// HPS ioctl upload responder: serves byte reads from a shared memory read port.
// Optional UPLOAD_CHECKSUM_EN: address DEPTH returns the running sum of in-range bytes.
module ioctl_upload_reader #(
  parameter int          ADDR_W       = 10,
  parameter logic [7:0]  UPLOAD_INDEX = 8'd4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic [7:0]        mem_q,
  output logic              active
);

  // state | meaning
  // IDLE  | waiting for a captured read strobe
  // REQ   | requesting the memory port, holding until granted
  // DATA  | memory byte valid this cycle, return it to the HPS
  // DONE  | out-of-range address, return the fixed/checksum byte
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_DONE} state_t;

  localparam logic [24:0] DEPTH = 25'(1) << ADDR_W;

  state_t      r_state;
  logic        r_rd;
  logic [24:0] r_addr;
  logic        w_match;
  logic        w_in_range;
  logic [7:0]  w_oor_byte;

  assign w_match    = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign w_in_range = (r_addr < DEPTH);

`ifdef UPLOAD_CHECKSUM_EN
  logic [7:0] r_sum;
  assign w_oor_byte = (r_addr == DEPTH) ? r_sum : 8'hFF;
`else
  assign w_oor_byte = 8'hFF;
`endif

  // The strobe is registered first so the FSM acts one edge after the HPS
  // sample; this yields the two-cycle wait window for an immediate grant.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rd       <= 1'b0;
      r_addr     <= '0;
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      active     <= 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
      r_sum      <= 8'h00;
`endif
    end else begin
      active <= w_match;
      r_rd   <= 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
      if (w_match && !active)
        r_sum <= 8'h00;
`endif
      if (!w_match) begin
        // Session ended: drop everything, keep the last returned byte.
        r_state    <= S_IDLE;
        mem_req    <= 1'b0;
        ioctl_wait <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (active && ioctl_rd && !r_rd) begin
              r_rd   <= 1'b1;
              r_addr <= ioctl_addr;
            end
            if (r_rd) begin
              ioctl_wait <= 1'b1;
              if (w_in_range) begin
                r_state  <= S_REQ;
                mem_req  <= 1'b1;
                mem_addr <= r_addr[ADDR_W-1:0];
              end else begin
                r_state <= S_DONE;
              end
            end
          end
          S_REQ: begin
            if (mem_gnt) begin
              mem_req <= 1'b0;
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            ioctl_din  <= mem_q;
`ifdef UPLOAD_CHECKSUM_EN
            r_sum      <= r_sum + mem_q;
`endif
            ioctl_wait <= 1'b0;
            r_state    <= S_IDLE;
          end
          S_DONE: begin
            ioctl_din  <= w_oor_byte;
            ioctl_wait <= 1'b0;
            r_state    <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Scoreboard bench for ioctl_upload_reader: expected bytes queued at issue, checked on wait fall.
module tb_ioctl_upload_reader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic        mem_gnt = 1'b0;
  logic [7:0]  mem_q = 8'h00;
  logic        active;

  ioctl_upload_reader #(.ADDR_W(10), .UPLOAD_INDEX(8'd4)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_q(mem_q), .active(active)
  );

  always #5 clk_sys = ~clk_sys;

`ifdef UPLOAD_CHECKSUM_EN
  localparam logic [7:0] EXP_SUM = 8'h25;
`else
  localparam logic [7:0] EXP_SUM = 8'hFF;
`endif

  typedef struct {logic [7:0] din; int wlen;} exp_t;
  exp_t sb[$];
  exp_t e_pop;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mem [0:1023];
  int gnt_delay = 0;
  int gcnt = 0;
  int req_cnt = 0;
  logic [9:0] last_maddr = '0;
  logic [7:0] last_din = 8'h00;
  int wlen = 0;
  logic prev_w = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Arbiter model: grant after gnt_delay cycles of request, data one cycle later.
  always @(negedge clk_sys) begin
    if (mem_req) begin
      req_cnt++;
      last_maddr = mem_addr;
      mem_gnt = (gcnt == gnt_delay);
      gcnt++;
    end else begin
      gcnt = 0;
      mem_gnt = 1'b0;
    end
  end

  always @(posedge clk_sys)
    if (mem_gnt) mem_q <= mem[mem_addr];

  // Monitor: every falling edge of ioctl_wait is a response.
  always @(negedge clk_sys) begin
    if (ioctl_wait) begin
      wlen++;
    end else begin
      if (prev_w) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_response: got din %0h expected none", ioctl_din);
        end else begin
          e_pop = sb.pop_front();
          chk("resp_din", 32'(ioctl_din), 32'(e_pop.din));
          if (e_pop.wlen >= 0) chk("resp_wait_len", wlen, e_pop.wlen);
        end
      end
      wlen = 0;
    end
    prev_w = ioctl_wait;
  end

  task automatic do_read(input logic [24:0] a, input logic [7:0] ed, input int ewlen,
                         input int ereq, input logic extra_rd);
    int r0;
    int t;
    @(negedge clk_sys);
    r0 = req_cnt;
    sb.push_back('{ed, ewlen});
    last_din = ed;
    ioctl_addr = a;
    ioctl_rd = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    if (extra_rd) begin
      repeat (2) @(negedge clk_sys);
      ioctl_addr = 25'h2;
      ioctl_rd = 1'b1;
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
    end
    t = 0;
    while ((sb.size() != 0 || ioctl_wait) && t < 100) begin
      @(negedge clk_sys);
      t++;
    end
    if (t >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL read_timeout: got no response for addr %0h expected one", a);
    end
    chk("req_cycles", req_cnt - r0, ereq);
    if (ereq > 0) chk("mem_addr", 32'(last_maddr), 32'(a[9:0]));
  endtask

  initial begin
    int r0;
    int t;
    logic saw_wait;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'hF5; mem[3] = 8'h5A;
    mem[5] = 8'h55; mem[7] = 8'h77; mem[1023] = 8'hC3;

    repeat (3) @(negedge clk_sys);
    chk("rst_din", 32'(ioctl_din), 32'h00);
    chk("rst_wait", 32'(ioctl_wait), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_maddr", 32'(mem_addr), 32'h0);
    chk("rst_active", 32'(active), 32'h0);
    reset = 1'b0;
    ioctl_upload = 1'b1;
    ioctl_index = 8'd4;
    repeat (2) @(negedge clk_sys);
    chk("active_on", 32'(active), 32'h1);

    do_read(25'h003, 8'h5A, 2, 1, 1'b0);
    gnt_delay = 5;
    do_read(25'h001, 8'h20, 7, 6, 1'b1);
    gnt_delay = 0;
    do_read(25'h3FF, 8'hC3, 2, 1, 1'b0);
    do_read(25'h401, 8'hFF, 1, 0, 1'b0);
    do_read(25'h1000400, 8'hFF, 1, 0, 1'b0);

    // New session clears the checksum.
    @(negedge clk_sys); ioctl_upload = 1'b0;
    repeat (2) @(negedge clk_sys); ioctl_upload = 1'b1;
    repeat (2) @(negedge clk_sys);
    do_read(25'h000, 8'h10, 2, 1, 1'b0);
    do_read(25'h001, 8'h20, 2, 1, 1'b0);
    do_read(25'h002, 8'hF5, 2, 1, 1'b0);
    do_read(25'h400, EXP_SUM, 1, 0, 1'b0);
    do_read(25'h400, EXP_SUM, 1, 0, 1'b0);

    // Upload dropped while waiting for grant.
    gnt_delay = 20;
    @(negedge clk_sys);
    sb.push_back('{last_din, -1});
    ioctl_addr = 25'h005;
    ioctl_rd = 1'b1;
    @(negedge clk_sys); ioctl_rd = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("abort_req_before", 32'(mem_req), 32'h1);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    chk("abort_req", 32'(mem_req), 32'h0);
    chk("abort_wait", 32'(ioctl_wait), 32'h0);
    chk("abort_din", 32'(ioctl_din), 32'(last_din));
    gnt_delay = 0;

    // Wrong index: reads ignored.
    ioctl_upload = 1'b1;
    ioctl_index = 8'd0;
    repeat (2) @(negedge clk_sys);
    chk("active_wrong_idx", 32'(active), 32'h0);
    r0 = req_cnt;
    saw_wait = 1'b0;
    ioctl_addr = 25'h005;
    ioctl_rd = 1'b1;
    @(negedge clk_sys); ioctl_rd = 1'b0;
    repeat (5) begin
      @(negedge clk_sys);
      if (ioctl_wait) saw_wait = 1'b1;
    end
    chk("idx0_wait", 32'(saw_wait), 32'h0);
    chk("idx0_req", req_cnt - r0, 0);
    ioctl_index = 8'd4;
    repeat (2) @(negedge clk_sys);

    // Reset pulsed while in DATA.
    @(negedge clk_sys);
    sb.push_back('{8'h00, -1});
    ioctl_addr = 25'h007;
    ioctl_rd = 1'b1;
    @(negedge clk_sys); ioctl_rd = 1'b0;
    t = 0;
    while (!mem_req && t < 20) begin
      @(negedge clk_sys);
      t++;
    end
    if (t >= 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL data_reset_setup: got no mem_req expected one");
    end
    @(negedge clk_sys);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_din", 32'(ioctl_din), 32'h00);
    chk("mid_rst_wait", 32'(ioctl_wait), 32'h0);
    chk("mid_rst_req", 32'(mem_req), 32'h0);
    chk("mid_rst_maddr", 32'(mem_addr), 32'h0);
    chk("mid_rst_active", 32'(active), 32'h0);
    @(negedge clk_sys);
    reset = 1'b0;
    r0 = req_cnt;
    repeat (4) @(negedge clk_sys);
    chk("post_rst_no_req", req_cnt - r0, 0);
    do_read(25'h003, 8'h5A, 2, 1, 1'b0);

    repeat (3) @(negedge clk_sys);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
